// File: rtl/load_store_queue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_queue_pkg : shared op codes, widths, FSM states and load helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package load_store_queue_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int LSB_WIDTH = 3;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsq_state_e;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_LB:   return {{24{d[7]}}, d[7:0]};
      OP_LH:   return {{16{d[15]}}, d[15:0]};
      OP_LBU:  return {24'h0, d[7:0]};
      OP_LHU:  return {16'h0, d[15:0]};
      OP_LW:   return d;
      default: return d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_queue_wakeup.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsq_wakeup : CDB_N-way tag match and value select, lowest channel wins
// Rev 1.0
// ----------------------------------------------------------------------------
module lsq_wakeup #(
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic [ROB_W-1:0]       tag_i,
  input  logic [CDB_N-1:0]       cdb_valid_i,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob_i,
  input  logic [CDB_N*32-1:0]    cdb_val_i,
  output logic                   hit_o,
  output logic [31:0]            val_o
);

  // Scanning downward lets the lowest matching channel overwrite the others.
  always_comb begin
    hit_o = 1'b0;
    val_o = 32'h0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (cdb_valid_i[c] && (cdb_rob_i[c*ROB_W +: ROB_W] == tag_i)) begin
        hit_o = 1'b1;
        val_o = cdb_val_i[c*32 +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_queue : in-order LSQ with CDB wakeup, store commit and flush.
// Build macro LSQ_LOAD_EXT_EN: sign/zero-extend load data inside the queue.
// Rev 1.0
// ----------------------------------------------------------------------------
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = 1 << LSB_WIDTH,
  parameter int ROB_W = ROB_WIDTH,
  parameter int CDB_N = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  output logic                   full,
  input  logic                   iss_valid,
  input  logic [3:0]             iss_type,
  input  logic [31:0]            iss_vj,
  input  logic [31:0]            iss_vk,
  input  logic                   iss_dj,
  input  logic                   iss_dk,
  input  logic [ROB_W-1:0]       iss_qj,
  input  logic [ROB_W-1:0]       iss_qk,
  input  logic [31:0]            iss_imm,
  input  logic [ROB_W-1:0]       iss_rob,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob,
  input  logic [CDB_N*32-1:0]    cdb_val,
  input  logic                   commit_valid,
  input  logic [ROB_W-1:0]       commit_rob,
  output logic                   mem_req,
  output logic [3:0]             mem_type,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_done,
  input  logic [31:0]            mem_rdata,
  output logic                   out_valid,
  output logic [ROB_W-1:0]       out_rob,
  output logic [31:0]            out_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] busy_q, dj_q, dk_q, cmt_q;
  logic [3:0]       type_q [DEPTH];
  logic [31:0]      vj_q   [DEPTH];
  logic [31:0]      vk_q   [DEPTH];
  logic [31:0]      imm_q  [DEPTH];
  logic [ROB_W-1:0] qj_q   [DEPTH];
  logic [ROB_W-1:0] qk_q   [DEPTH];
  logic [ROB_W-1:0] rob_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, keep_cnt;

  lsq_state_e       state_q;
  logic             mem_req_q, out_valid_q;
  logic [3:0]       mem_type_q;
  logic [31:0]      mem_addr_q, mem_wdata_q, out_val_q;
  logic [ROB_W-1:0] out_rob_q;

  logic [DEPTH-1:0] wj_hit, wk_hit, cmt_hit, keep;
  logic [31:0]      wj_val [DEPTH];
  logic [31:0]      wk_val [DEPTH];
  logic             ij_hit, ik_hit;
  logic [31:0]      ij_val, ik_val;
  logic             retire, iss_ok, h_store, h_ready;
  logic [31:0]      ld_data;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      lsq_wakeup #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_wj (
        .tag_i(qj_q[i]), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
        .cdb_val_i(cdb_val), .hit_o(wj_hit[i]), .val_o(wj_val[i])
      );
      lsq_wakeup #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_wk (
        .tag_i(qk_q[i]), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
        .cdb_val_i(cdb_val), .hit_o(wk_hit[i]), .val_o(wk_val[i])
      );
      assign cmt_hit[i] = commit_valid && busy_q[i] && is_store(type_q[i]) &&
                          (rob_q[i] == commit_rob);
      // Committed stores survive a flush; the entry retiring this cycle never does.
      assign keep[i] = busy_q[i] && is_store(type_q[i]) && (cmt_q[i] || cmt_hit[i]) &&
                       !(retire && (head_q == PTR_W'(i)));
    end
  endgenerate

  lsq_wakeup #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_iss_j (
    .tag_i(iss_qj), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
    .cdb_val_i(cdb_val), .hit_o(ij_hit), .val_o(ij_val)
  );
  lsq_wakeup #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_iss_k (
    .tag_i(iss_qk), .cdb_valid_i(cdb_valid), .cdb_rob_i(cdb_rob),
    .cdb_val_i(cdb_val), .hit_o(ik_hit), .val_o(ik_val)
  );

  assign full    = (count_q == CNT_W'(DEPTH));
  assign retire  = (state_q == ST_RESP);
  assign iss_ok  = iss_valid && !clear && (!full || retire);
  assign h_store = is_store(type_q[head_q]);
  assign h_ready = busy_q[head_q] && !dj_q[head_q] && !dk_q[head_q] &&
                   (!h_store || cmt_q[head_q]);

`ifdef LSQ_LOAD_EXT_EN
  assign ld_data = load_extend(type_q[head_q], mem_rdata);
`else
  assign ld_data = mem_rdata;
`endif

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep_cnt = keep_cnt + CNT_W'(keep[i]);
    end
    head_d = retire ? head_q + PTR_W'(1) : head_q;
    if (clear) begin
      count_d = keep_cnt;
      tail_d  = head_d + keep_cnt[PTR_W-1:0];
    end else begin
      count_d = count_q;
      tail_d  = tail_q;
      if (iss_ok) begin
        count_d = count_d + CNT_W'(1);
        tail_d  = tail_q + PTR_W'(1);
      end
      if (retire) begin
        count_d = count_d - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Issue is written last so it wins over a retire of the same slot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      dj_q   <= '0;
      dk_q   <= '0;
      cmt_q  <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && dj_q[i] && wj_hit[i]) begin
          vj_q[i] <= wj_val[i];
          dj_q[i] <= 1'b0;
        end
        if (busy_q[i] && dk_q[i] && wk_hit[i]) begin
          vk_q[i] <= wk_val[i];
          dk_q[i] <= 1'b0;
        end
        if (cmt_hit[i]) begin
          cmt_q[i] <= 1'b1;
        end
        if ((retire && (head_q == PTR_W'(i))) || (clear && !keep[i])) begin
          busy_q[i] <= 1'b0;
          cmt_q[i]  <= 1'b0;
        end
      end
      if (iss_ok) begin
        busy_q[tail_q] <= 1'b1;
        cmt_q[tail_q]  <= 1'b0;
        type_q[tail_q] <= iss_type;
        imm_q[tail_q]  <= iss_imm;
        rob_q[tail_q]  <= iss_rob;
        qj_q[tail_q]   <= iss_qj;
        qk_q[tail_q]   <= iss_qk;
        vj_q[tail_q]   <= (iss_dj && ij_hit) ? ij_val : iss_vj;
        vk_q[tail_q]   <= (iss_dk && ik_hit) ? ik_val : iss_vk;
        dj_q[tail_q]   <= iss_dj && !ij_hit;
        dk_q[tail_q]   <= iss_dk && !ik_hit;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_type_q  <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      out_valid_q <= 1'b0;
      out_rob_q   <= '0;
      out_val_q   <= 32'h0;
    end else if (rdy_in) begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (h_ready && !(clear && !h_store)) begin
            state_q     <= ST_MEM;
            mem_req_q   <= 1'b1;
            mem_type_q  <= type_q[head_q];
            mem_addr_q  <= vj_q[head_q] + imm_q[head_q];
            mem_wdata_q <= h_store ? vk_q[head_q] : 32'h0;
          end
        end
        ST_MEM: begin
          // Only loads can be in flight uncommitted, so a flush abandons them.
          if (clear && !h_store) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end else if (mem_done) begin
            state_q     <= ST_RESP;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_rob_q   <= rob_q[head_q];
            out_val_q   <= h_store ? 32'h0 : ld_data;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_type  = mem_type_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign out_rob   = out_rob_q;
  assign out_val   = out_val_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_queue : directed self-checking bench for load_store_queue
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, full;
  logic        iss_valid, iss_dj, iss_dk;
  logic [3:0]  iss_type, iss_qj, iss_qk, iss_rob;
  logic [31:0] iss_vj, iss_vk, iss_imm;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob;
  logic [63:0] cdb_val;
  logic        commit_valid;
  logic [3:0]  commit_rob;
  logic        mem_req, mem_done, out_valid;
  logic [3:0]  mem_type, out_rob;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, out_val;

  int checks = 0;
  int errors = 0;

  load_store_queue #(.DEPTH(8), .ROB_W(4), .CDB_N(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .full(full),
    .iss_valid(iss_valid), .iss_type(iss_type), .iss_vj(iss_vj), .iss_vk(iss_vk),
    .iss_dj(iss_dj), .iss_dk(iss_dk), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .iss_imm(iss_imm), .iss_rob(iss_rob), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_val(cdb_val), .commit_valid(commit_valid), .commit_rob(commit_rob),
    .mem_req(mem_req), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_rob(out_rob), .out_val(out_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] t, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [31:0] imm, input logic dj, input logic dk,
                           input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob);
    iss_valid = 1'b1; iss_type = t; iss_vj = vj; iss_vk = vk; iss_imm = imm;
    iss_dj = dj; iss_dk = dk; iss_qj = qj; iss_qk = qk; iss_rob = rob;
  endtask

  task automatic do_issue(input logic [3:0] t, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [31:0] imm, input logic dj, input logic dk,
                          input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob);
    set_issue(t, vj, vk, imm, dj, dk, qj, qk, rob);
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic finish_mem();
    mem_done = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_done = 1'b0;
    tick();
  endtask

  task automatic reset_dut();
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; iss_valid = 1'b0;
    iss_type = 4'h0; iss_vj = 32'h0; iss_vk = 32'h0; iss_imm = 32'h0;
    iss_dj = 1'b0; iss_dk = 1'b0; iss_qj = 4'h0; iss_qk = 4'h0; iss_rob = 4'h0;
    cdb_valid = 2'b00; cdb_rob = 8'h0; cdb_val = 64'h0;
    commit_valid = 1'b0; commit_rob = 4'h0; mem_done = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (mem_addr !== 32'h0 || out_val !== 32'h0 || mem_type !== 4'h0 || mem_wdata !== 32'h0 || out_rob !== 4'h0)
      begin errors++; $display("FAIL reset_outputs: addr %h val %h type %h wdata %h rob %h want all 0", mem_addr, out_val, mem_type, mem_wdata, out_rob); end
  endtask

  task automatic test_load();
    reset_dut();
    do_issue(4'b0010, 32'h100, 32'h0, 32'h4, 1'b0, 1'b0, 4'h0, 4'h0, 4'd1);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_req_early: got %b want 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_type !== 4'b0010 || mem_wdata !== 32'h0)
      begin errors++; $display("FAIL load_req: req %b addr %h type %b wdata %h want 1 104 0010 0", mem_req, mem_addr, mem_type, mem_wdata); end
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin errors++; $display("FAIL load_req_hold: req %b addr %h want 1 104", mem_req, mem_addr); end
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_val !== 32'hDEADBEEF || out_rob !== 4'd1 || mem_req !== 1'b0)
      begin errors++; $display("FAIL load_resp: valid %b val %h rob %0d req %b want 1 deadbeef 1 0", out_valid, out_val, out_rob, mem_req); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_resp_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_store_wakeup();
    reset_dut();
    do_issue(4'b1010, 32'h200, 32'h0, 32'h8, 1'b0, 1'b1, 4'h0, 4'd3, 4'd5);
    cdb_valid = 2'b11; cdb_rob = {4'd3, 4'd7}; cdb_val = {32'h55, 32'h99};
    tick();
    cdb_valid = 2'b00;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL store_uncommitted: req %b want 0", mem_req); end
    commit_valid = 1'b1; commit_rob = 4'd5;
    tick();
    commit_valid = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_wdata !== 32'h55 || mem_addr !== 32'h208 || mem_type !== 4'b1010)
      begin errors++; $display("FAIL store_req: req %b wdata %h addr %h type %b want 1 55 208 1010", mem_req, mem_wdata, mem_addr, mem_type); end
    mem_done = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_val !== 32'h0 || out_rob !== 4'd5)
      begin errors++; $display("FAIL store_resp: valid %b val %h rob %0d want 1 0 5", out_valid, out_val, out_rob); end
    tick();
  endtask

  task automatic test_wakeup_paths();
    reset_dut();
    set_issue(4'b0010, 32'h0, 32'h0, 32'h10, 1'b1, 1'b0, 4'd2, 4'h0, 4'd8);
    cdb_valid = 2'b10; cdb_rob = {4'd2, 4'd0}; cdb_val = {32'h300, 32'h0};
    tick();
    iss_valid = 1'b0; cdb_valid = 2'b00;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h310) begin errors++; $display("FAIL issue_capture: req %b addr %h want 1 310", mem_req, mem_addr); end
    finish_mem();
    do_issue(4'b0010, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 4'd6, 4'h0, 4'd9);
    cdb_valid = 2'b11; cdb_rob = {4'd6, 4'd6}; cdb_val = {32'h2000, 32'h1000};
    tick();
    cdb_valid = 2'b00;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1004) begin errors++; $display("FAIL cdb_priority: req %b addr %h want 1 1004", mem_req, mem_addr); end
    finish_mem();
  endtask

  task automatic test_full_wrap();
    logic [3:0]  exp_rob;
    logic [31:0] exp_addr;
    int n;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      set_issue(4'b0010, 32'(i * 16), 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'(i));
      tick();
    end
    iss_valid = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
    do_issue(4'b0010, 32'h900, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd9);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_drop: got %b want 1", full); end
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rob !== 4'd0) begin errors++; $display("FAIL full_first_resp: valid %b rob %0d want 1 0", out_valid, out_rob); end
    do_issue(4'b0010, 32'hA0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd10);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_swap: got %b want 1", full); end
    for (int k = 0; k < 8; k++) begin
      exp_rob  = (k < 7) ? 4'(k + 1) : 4'd10;
      exp_addr = (k < 7) ? 32'((k + 1) * 16) : 32'hA0;
      n = 0;
      while (mem_req !== 1'b1 && n < 8) begin tick(); n++; end
      checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr)
        begin errors++; $display("FAIL drain_req[%0d]: req %b addr %h want 1 %h", k, mem_req, mem_addr, exp_addr); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_rob !== exp_rob)
        begin errors++; $display("FAIL drain_resp[%0d]: valid %b rob %0d want 1 %0d", k, out_valid, out_rob, exp_rob); end
      tick();
    end
    tick(); tick(); tick();
    checks++; if (full !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL drain_empty: full %b req %b want 0 0", full, mem_req); end
  endtask

  task automatic test_clear();
    logic seen;
    reset_dut();
    do_issue(4'b1000, 32'h40, 32'hAB, 32'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd2);
    commit_valid = 1'b1; commit_rob = 4'd2;
    tick();
    commit_valid = 1'b0;
    do_issue(4'b0010, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd3);
    do_issue(4'b0001, 32'h600, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd4);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h41 || mem_type !== 4'b1000 || mem_wdata !== 32'hAB)
      begin errors++; $display("FAIL clear_store_req: req %b addr %h type %b wdata %h want 1 41 1000 ab", mem_req, mem_addr, mem_type, mem_wdata); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (mem_req !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL clear_store_kept: req %b full %b want 1 0", mem_req, full); end
    mem_done = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rob !== 4'd2 || out_val !== 32'h0)
      begin errors++; $display("FAIL clear_store_resp: valid %b rob %0d val %h want 1 2 0", out_valid, out_rob, out_val); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (mem_req === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clear_loads_gone: saw req %b want 0", seen); end
    do_issue(4'b0010, 32'h700, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd6);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin errors++; $display("FAIL clear_new_head: req %b addr %h want 1 700", mem_req, mem_addr); end
    finish_mem();
    do_issue(4'b0010, 32'h800, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd11);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL clear_abort_load: req %b want 0", mem_req); end
    tick(); tick();
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || full !== 1'b0)
      begin errors++; $display("FAIL clear_abort_idle: req %b valid %b full %b want 0 0 0", mem_req, out_valid, full); end
  endtask

  task automatic test_freeze_and_reset_in_mem();
    reset_dut();
    rdy_in = 1'b0;
    do_issue(4'b0010, 32'h900, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd12);
    rdy_in = 1'b1;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL freeze_issue: req %b want 0", mem_req); end
    do_issue(4'b0010, 32'h930, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd13);
    tick();
    rdy_in = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h930) begin errors++; $display("FAIL freeze_hold: req %b addr %h want 1 930", mem_req, mem_addr); end
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_type !== 4'h0)
      begin errors++; $display("FAIL reset_in_mem: req %b addr %h type %h want 0 0 0", mem_req, mem_addr, mem_type); end
    tick(); tick();
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_abandon: req %b valid %b want 0 0", mem_req, out_valid); end
  endtask

  task automatic test_load_ext();
    logic [31:0] exp_b, exp_hu;
`ifdef LSQ_LOAD_EXT_EN
    exp_b  = 32'hFFFFFF80;
    exp_hu = 32'h00008001;
`else
    exp_b  = 32'h00000080;
    exp_hu = 32'hFFFF8001;
`endif
    reset_dut();
    do_issue(4'b0000, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd7);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_type !== 4'b0000) begin errors++; $display("FAIL lb_req: req %b type %b want 1 0000", mem_req, mem_type); end
    mem_done = 1'b1; mem_rdata = 32'h00000080;
    tick();
    mem_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_val !== exp_b) begin errors++; $display("FAIL lb_ext: valid %b val %h want 1 %h", out_valid, out_val, exp_b); end
    tick();
    do_issue(4'b0101, 32'h24, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd8);
    tick();
    mem_done = 1'b1; mem_rdata = 32'hFFFF8001;
    tick();
    mem_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_val !== exp_hu) begin errors++; $display("FAIL lhu_ext: valid %b val %h want 1 %h", out_valid, out_val, exp_hu); end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_store_wakeup();
    test_wakeup_paths();
    test_full_wrap();
    test_clear();
    test_freeze_and_reset_in_mem();
    test_load_ext();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, at least 2.
REQ-002 Parameter ROB_W, default 4, ROB tag width.
REQ-003 Parameter CDB_N, default 2, number of result-broadcast channels snooped.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk_in  in  1  clock.
- rst_in  in  1  sync active-high reset.
- rdy_in  in  1  low freezes all state.
- clear  in  1  mispredict flush.
- full  out  1  queue full.
- iss_valid  in  1  issue strobe.
- iss_type  in  4  op code.
- iss_vj  in  32  base value.
- iss_vk  in  32  store data.
- iss_dj, iss_dk  in  1 each  operand pending.
- iss_qj, iss_qk  in  ROB_W each  producer tags.
- iss_imm  in  32  offset.
- iss_rob  in  ROB_W  destination tag.
- cdb_valid  in  CDB_N  broadcast valids.
- cdb_rob  in  CDB_N*ROB_W  broadcast tags.
- cdb_val  in  CDB_N*32  broadcast values.
- commit_valid  in  1  ROB commits a store.
- commit_rob  in  ROB_W  tag of that store.
- mem_req  out  1  memory request, level.
- mem_type  out  4  access type.
- mem_addr  out  32  address.
- mem_wdata  out  32  store data.
- mem_done  in  1  memory completion pulse.
- mem_rdata  in  32  load data.
- out_valid  out  1  result pulse.
- out_rob  out  ROB_W  result tag.
- out_val  out  32  result value.

Function
REQ-006 Storage is a circular queue with head, tail and count registers; full is count==DEPTH; pointers wrap modulo DEPTH; no slot is wasted.
REQ-007 Op codes: LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010; bit 3 set means store.
REQ-008 Issue writes the entry at tail. If a same-cycle CDB tag matches qj or qk, that value is captured and the pending flag is cleared. iss_valid while full is dropped.
REQ-009 Every cycle, each busy entry with a pending operand captures the value from any cdb channel whose tag matches; if several channels match, the lowest index wins.
REQ-010 commit_valid sets the committed flag of the busy store entry whose rob tag equals commit_rob.
REQ-011 Head FSM states are IDLE, MEM and RESP.
- IDLE to MEM when the head is busy, dj and dk are clear, and the head is a load or a committed store.
- MEM holds mem_req=1 with stable type, addr and wdata until mem_done, then goes to RESP.
- RESP drives a one-cycle out_valid, advances head, and returns to IDLE.
REQ-012 mem_addr = vj + imm (mod 2^32) for both loads and stores; mem_wdata = vk for stores and 0 for loads.
REQ-013 out_val = 0 for stores and the load data for loads; out_rob is the head entry's tag.
REQ-014 Latency: a ready head sees mem_req the next cycle; out_valid follows one cycle after mem_done; the next request starts no earlier than the cycle after RESP.
REQ-015 Issue and retire in the same cycle leave count unchanged; issuing into the slot freed that cycle is legal.
REQ-016 clear discards every uncommitted entry. Tail becomes head plus the committed-store count. If the head is an uncommitted load in MEM, the FSM returns to IDLE and mem_req drops the next cycle; a committed store in MEM completes normally.
REQ-017 rdy_in=0 holds all registers; mem_done arriving while rdy_in=0 is out of protocol.

Reset
REQ-018 rst_in clears head, tail, count, every busy/dj/dk/committed flag, and the FSM (to IDLE).
REQ-019 rst_in forces mem_req, out_valid, mem_type, mem_addr, mem_wdata, out_rob and out_val to 0, and full to 0, the cycle after rst_in.
REQ-020 Reset during MEM abandons the access.

Configuration
REQ-021 Macro LSQ_LOAD_EXT_EN:
- Defined: loads return extended data. LB/LH sign-extend mem_rdata[7:0]/[15:0]; LBU/LHU zero-extend; LW passes through.
- Undefined: out_val = mem_rdata unmodified, and memctrl performs extension.

Structure
REQ-022 Op-code constants, ROB_WIDTH and LSB_WIDTH belong in the shared defines package.
REQ-023 One sub-module, lsq_wakeup, implements per-entry CDB_N-way tag match and value select; it is instantiated once per operand per entry.

Verification
REQ-024 LW issued with vj=0x100, imm=4, no deps → mem_req next cycle with addr=0x104, type=0010; mem_done with rdata=0xDEADBEEF → out_valid next cycle, out_val=0xDEADBEEF.
REQ-025 SW with dk pending on tag 3 → cdb channel 1 broadcasts tag 3, value 0x55; commit_valid for the store's tag → mem_wdata=0x55; out_val=0 after mem_done.
REQ-026 Fill DEPTH entries → full=1; the extra issue is dropped; retiring one entry while issuing one in the same cycle keeps full=1 and wraps tail to 0.
REQ-027 Committed SB in MEM plus two younger loads, then clear → the store completes with out_valid; the loads never issue; count=0 afterwards.
REQ-028 LB returning rdata=0x00000080 → out_val=0xFFFFFF80 with LSQ_LOAD_EXT_EN defined, 0x00000080 without.
